// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array tile feeder: default sizes,
// the feeder state encoding, the data word type and a width helper.
package sa_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_N      = 4;

    typedef logic [DEF_DATA_W-1:0] data_word_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DRAIN  = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } feeder_state_t;

    // Counter width that never collapses to zero bits for tiny tiles.
    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sa_tile_buffer.sv
// Tile staging register file: one synchronous write port fed from memory,
// RD_PORTS combinational read ports (one per array row). Contents are not
// reset; every entry is rewritten by each load before it is read.
module sa_tile_buffer
    import sa_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_N * DEF_N,
    parameter int IDX_W    = clog2_min1(DEF_N * DEF_N),
    parameter int RD_PORTS = DEF_N
)(
    input  logic                         i_clk,
    input  logic                         i_wr_en,
    input  logic [IDX_W-1:0]             i_wr_idx,
    input  logic [DATA_W-1:0]            i_wr_data,
    input  logic [RD_PORTS*IDX_W-1:0]    i_rd_idx,
    output logic [RD_PORTS*DATA_W-1:0]   o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Capture one returned memory word per cycle.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    // Independent combinational read per row.
    always_comb begin
        o_rd_data = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            o_rd_data[p*DATA_W +: DATA_W] = r_mem[i_rd_idx[p*IDX_W +: IDX_W]];
        end
    end

endmodule

// File: rtl/sa_tile_feeder.sv
// Tile feeder: reads an N x N row-major tile from the single-port memory
// into a local buffer, then streams it into the array west edge with a
// one-step skew per row (row i sees A[i][k] at step k+i).
//
//  state  | meaning
//  -------+---------------------------------------------------------
//  IDLE   | waiting for i_start; base address latched with it
//  LOAD   | one memory read per cycle, N*N cycles, data lands 1 later
//  DRAIN  | capture the last returned word, no read issued
//  STREAM | present skewed step t; t advances only when array ready
//  DONE   | one-cycle completion pulse, back to IDLE
module sa_tile_feeder
    import sa_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int N      = DEF_N
)(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_base_addr,
    input  logic                  i_array_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_en,
    output logic                  o_mem_write,
    output logic [ADDR_W-1:0]     o_mem_addr,
    input  logic [DATA_W-1:0]     i_mem_data,
    output logic [N*DATA_W-1:0]   o_out_data,
    output logic [N-1:0]          o_out_valid
);

    localparam int CELLS = N * N;
    localparam int CNT_W = clog2_min1(CELLS + 1);
    localparam int T_W   = clog2_min1(2 * N);
    localparam int IDX_W = clog2_min1(CELLS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELLS - 1);
    localparam logic [T_W-1:0]   T_LAST   = T_W'(2 * N - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CELLS - 1);

    if (CELLS > 2 ** ADDR_W) begin : g_size_check
        $error("sa_tile_feeder: tile does not fit in the address space");
    end

    feeder_state_t           r_state;
    feeder_state_t           w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [T_W-1:0]          r_step;
    logic [ADDR_W-1:0]       r_base;

    logic                    w_busy;
    logic                    w_done;
    logic                    w_mem_en;
    logic [ADDR_W-1:0]       w_rd_addr;

    logic                    w_wr_en;
    logic [IDX_W-1:0]        w_wr_idx;
    logic [N*IDX_W-1:0]      w_rd_idx;
    logic [N*DATA_W-1:0]     w_rd_data;
    logic [N-1:0]            w_row_valid;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded control outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_mem_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_busy   = 1'b1;
                w_mem_en = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_busy      = 1'b1;
                w_state_nxt = STREAM;
            end
            STREAM: begin
                w_busy = 1'b1;
                if (i_array_ready && (r_step == T_LAST)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Issue counter, stream step counter and latched base address.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_step <= '0;
            r_base <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt  <= '0;
                    r_step <= '0;
                    if (i_start) begin
                        r_base <= i_base_addr;
                    end
                end
                LOAD: begin
                    r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
                end
                STREAM: begin
                    if (i_array_ready) begin
                        r_step <= (r_step == T_LAST) ? '0 : r_step + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Address sum wraps naturally at the top of the address space.
    assign w_rd_addr   = r_base + ADDR_W'(r_cnt);

    assign o_busy      = w_busy;
    assign o_done      = w_done;
    assign o_mem_en    = w_mem_en;
    assign o_mem_write = 1'b0;
    assign o_mem_addr  = w_mem_en ? w_rd_addr : '0;

    // Read data returns one cycle after issue, so entry c is written while
    // read c+1 goes out; DRAIN catches the final word.
    assign w_wr_en  = ((r_state == LOAD) && (r_cnt != '0)) || (r_state == DRAIN);
    assign w_wr_idx = (r_state == DRAIN) ? IDX_LAST : IDX_W'(r_cnt - 1'b1);

    sa_tile_buffer #(
        .DATA_W   (DATA_W),
        .DEPTH    (CELLS),
        .IDX_W    (IDX_W),
        .RD_PORTS (N)
    ) u_tile_buffer (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_wr_idx),
        .i_wr_data (i_mem_data),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data)
    );

    // Skew decode: row i is active for steps i..i+N-1 and reads column t-i.
    always_comb begin
        w_row_valid = '0;
        w_rd_idx    = '0;
        if (r_state == STREAM) begin
            for (int i = 0; i < N; i++) begin
                if ((int'(r_step) >= i) && (int'(r_step) <= i + N - 1)) begin
                    w_row_valid[i]               = 1'b1;
                    w_rd_idx[i*IDX_W +: IDX_W]   = IDX_W'(i * N + int'(r_step) - i);
                end
            end
        end
    end

    // Inactive rows and non-stream states present zero data.
    always_comb begin
        o_out_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_row_valid[i]) begin
                o_out_data[i*DATA_W +: DATA_W] = w_rd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign o_out_valid = w_row_valid;

endmodule

// File: tb/tb_sa_tile_feeder.sv
// Bench for sa_tile_feeder: sync memory model, per-cycle capture of the
// stream, and a tile/skew reference computed from the memory image.
module tb_sa_tile_feeder;
    import sa_pkg::*;

    localparam int N  = DEF_N;
    localparam int DW = DEF_DATA_W;
    localparam int AW = DEF_ADDR_W;
    localparam int LAT_DONE = N*N + 2*N + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [AW-1:0]     i_base_addr;
    logic              i_array_ready;
    logic              o_busy, o_done, o_mem_en, o_mem_write;
    logic [AW-1:0]     o_mem_addr;
    logic [DW-1:0]     mem_data;
    logic [N*DW-1:0]   o_out_data;
    logic [N-1:0]      o_out_valid;

    logic [DW-1:0]     mem [256];

    int n_checks = 0;
    int n_pass   = 0;

    logic [N*DW-1:0]   log_data [$];
    logic [N-1:0]      log_valid [$];
    bit                log_ready [$];
    logic [AW-1:0]     addr_q [$];
    int                done_cycle, done_cnt, busy_cnt, wr_bad;

    always #5 clk = ~clk;

    // Synchronous read memory: data valid the cycle after the address.
    always @(posedge clk) begin
        if (o_mem_en) mem_data <= mem[o_mem_addr];
    end

    sa_tile_feeder dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (i_start),
        .i_base_addr   (i_base_addr),
        .i_array_ready (i_array_ready),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_mem_en      (o_mem_en),
        .o_mem_write   (o_mem_write),
        .o_mem_addr    (o_mem_addr),
        .i_mem_data    (mem_data),
        .o_out_data    (o_out_data),
        .o_out_valid   (o_out_valid)
    );

    task automatic load_default();
        for (int a = 0; a < 256; a++) mem[a] = DW'((a + 1) * 10);
    endtask

    // Reference: tile A[r][k] = mem[base + r*N + k]; row i shows A[i][t-i].
    function automatic void exp_step(input logic [AW-1:0] base, input int t,
                                     output logic [N-1:0] ev, output logic [N*DW-1:0] ed);
        logic [AW-1:0] a;
        ev = '0;
        ed = '0;
        for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < N) begin
                a = base + AW'(i * N + (t - i));
                ev[i] = 1'b1;
                ed[i*DW +: DW] = mem[a];
            end
        end
    endfunction

    // Runs one transfer and records what the DUT did each cycle.
    task automatic run_capture(input logic [AW-1:0] base, input int stall_at, input int stall_len,
                               input bit rand_rdy, input bit extra_starts);
        int  accepted, stalled;
        bit  rdy, in_stream;
        log_data.delete(); log_valid.delete(); log_ready.delete(); addr_q.delete();
        done_cycle = -1; done_cnt = 0; busy_cnt = 0; wr_bad = 0;
        accepted = 0; stalled = 0;
        @(negedge clk);
        i_base_addr = base;
        i_start     = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 300; k++) begin
            #1;
            if (k == 1) i_base_addr = AW'($urandom);
            if (o_done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = k;
            end
            if (o_busy) busy_cnt++;
            if (o_mem_en) addr_q.push_back(o_mem_addr);
            if (o_mem_write !== 1'b0) wr_bad++;
            i_start = extra_starts && (k == 5 || k == 20);
            in_stream = (o_out_valid !== '0) || (o_out_data !== '0);
            if (in_stream) begin
                if (stall_at >= 0) rdy = !(accepted == stall_at && stalled < stall_len);
                else if (rand_rdy) rdy = ($urandom_range(0, 2) != 0);
                else rdy = 1'b1;
                if (!rdy) stalled++;
                if (rdy) accepted++;
                log_data.push_back(o_out_data);
                log_valid.push_back(o_out_valid);
                log_ready.push_back(rdy);
            end else begin
                rdy = rand_rdy ? ($urandom_range(0, 1) != 0) : 1'b1;
            end
            i_array_ready = rdy;
            if (done_cycle >= 0 && k >= done_cycle + 2) break;
            @(posedge clk);
        end
        i_start = 1'b0;
        i_array_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_array_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", o_busy); else n_pass++;
        n_checks++; if (o_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", o_done); else n_pass++;
        n_checks++; if (o_mem_en !== 1'b0) $display("FAIL reset_mem_en: got %b expected 0", o_mem_en); else n_pass++;
        n_checks++; if (o_mem_write !== 1'b0) $display("FAIL reset_mem_write: got %b expected 0", o_mem_write); else n_pass++;
        n_checks++; if (o_mem_addr !== '0) $display("FAIL reset_mem_addr: got %h expected 0", o_mem_addr); else n_pass++;
        n_checks++; if (o_out_valid !== '0) $display("FAIL reset_valid: got %b expected 0", o_out_valid); else n_pass++;
        n_checks++; if (o_out_data !== '0) $display("FAIL reset_data: got %h expected 0", o_out_data); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [N-1:0] ev; logic [N*DW-1:0] ed; int t;
        load_default();
        run_capture(8'd0, -1, 0, 1'b0, 1'b0);
        n_checks++; if (done_cycle != LAT_DONE) $display("FAIL basic_done_cycle: got %0d expected %0d", done_cycle, LAT_DONE); else n_pass++;
        n_checks++; if (addr_q.size() != N*N) $display("FAIL basic_mem_en_cycles: got %0d expected %0d", addr_q.size(), N*N); else n_pass++;
        for (int c = 0; c < addr_q.size() && c < N*N; c++) begin
            n_checks++; if (addr_q[c] !== AW'(c)) $display("FAIL basic_addr[%0d]: got %0d expected %0d", c, addr_q[c], c); else n_pass++;
        end
        n_checks++; if (wr_bad != 0) $display("FAIL basic_mem_write: got %0d bad cycles expected 0", wr_bad); else n_pass++;
        n_checks++; if (busy_cnt != LAT_DONE - 1) $display("FAIL basic_busy_cycles: got %0d expected %0d", busy_cnt, LAT_DONE - 1); else n_pass++;
        if (log_data.size() >= 2*N - 1) begin
            n_checks++; if (log_data[0][DW-1:0] !== 16'd10 || log_valid[0] !== 4'b0001)
                $display("FAIL basic_step0: got %0d/%b expected 10/0001", log_data[0][DW-1:0], log_valid[0]); else n_pass++;
            n_checks++; if (log_data[3] !== {16'd130, 16'd100, 16'd70, 16'd40} || log_valid[3] !== 4'b1111)
                $display("FAIL basic_step3: got %h/%b expected 0082006400460028/1111", log_data[3], log_valid[3]); else n_pass++;
            n_checks++; if (log_data[6][3*DW +: DW] !== 16'd160 || log_valid[6] !== 4'b1000)
                $display("FAIL basic_step6: got %0d/%b expected 160/1000", log_data[6][3*DW +: DW], log_valid[6]); else n_pass++;
        end
        t = 0;
        for (int j = 0; j < log_data.size(); j++) begin
            exp_step(8'd0, t, ev, ed);
            n_checks++; if (log_valid[j] !== ev) $display("FAIL basic_valid c%0d: got %b expected %b", j, log_valid[j], ev); else n_pass++;
            n_checks++; if (log_data[j] !== ed) $display("FAIL basic_data c%0d: got %h expected %h", j, log_data[j], ed); else n_pass++;
            if (log_ready[j]) t++;
        end
        n_checks++; if (log_data.size() != 2*N - 1) $display("FAIL basic_stream_len: got %0d expected %0d", log_data.size(), 2*N - 1); else n_pass++;
    endtask

    task automatic test_wrap();
        run_capture(8'd250, -1, 0, 1'b0, 1'b0);
        n_checks++; if (addr_q.size() != N*N) $display("FAIL wrap_mem_en_cycles: got %0d expected %0d", addr_q.size(), N*N); else n_pass++;
        if (addr_q.size() == N*N) begin
            n_checks++; if (addr_q[0] !== 8'd250) $display("FAIL wrap_addr0: got %0d expected 250", addr_q[0]); else n_pass++;
            n_checks++; if (addr_q[5] !== 8'd255) $display("FAIL wrap_addr5: got %0d expected 255", addr_q[5]); else n_pass++;
            n_checks++; if (addr_q[6] !== 8'd0) $display("FAIL wrap_addr6: got %0d expected 0", addr_q[6]); else n_pass++;
            n_checks++; if (addr_q[15] !== 8'd9) $display("FAIL wrap_addr15: got %0d expected 9", addr_q[15]); else n_pass++;
        end
        n_checks++; if (log_data.size() != 2*N - 1) $display("FAIL wrap_stream_len: got %0d expected %0d", log_data.size(), 2*N - 1);
        else begin
            n_pass++;
            n_checks++; if (log_data[0][DW-1:0] !== 16'h09CE) $display("FAIL wrap_step0_row0: got %h expected 09ce", log_data[0][DW-1:0]); else n_pass++;
            n_checks++; if (log_data[6][3*DW +: DW] !== 16'd100) $display("FAIL wrap_step6_row3: got %0d expected 100", log_data[6][3*DW +: DW]); else n_pass++;
        end
        n_checks++; if (done_cycle != LAT_DONE) $display("FAIL wrap_done_cycle: got %0d expected %0d", done_cycle, LAT_DONE); else n_pass++;
    endtask

    task automatic test_stall();
        logic [N-1:0] ev; logic [N*DW-1:0] ed; int t, stalls;
        run_capture(8'd0, 2, 3, 1'b0, 1'b0);
        t = 0; stalls = 0;
        for (int j = 0; j < log_data.size(); j++) begin
            exp_step(8'd0, t, ev, ed);
            n_checks++; if (log_valid[j] !== ev) $display("FAIL stall_valid c%0d: got %b expected %b", j, log_valid[j], ev); else n_pass++;
            n_checks++; if (log_data[j] !== ed) $display("FAIL stall_data c%0d: got %h expected %h", j, log_data[j], ed); else n_pass++;
            if (log_ready[j]) t++; else stalls++;
        end
        n_checks++; if (stalls != 3) $display("FAIL stall_count: got %0d expected 3", stalls); else n_pass++;
        n_checks++; if (log_data.size() != 2*N - 1 + 3) $display("FAIL stall_stream_len: got %0d expected %0d", log_data.size(), 2*N + 2); else n_pass++;
        n_checks++; if (done_cycle != LAT_DONE + 3) $display("FAIL stall_done_cycle: got %0d expected %0d", done_cycle, LAT_DONE + 3); else n_pass++;
    endtask

    task automatic test_start_ignored();
        run_capture(8'd16, -1, 0, 1'b0, 1'b1);
        n_checks++; if (done_cnt != 1) $display("FAIL ignore_done_count: got %0d expected 1", done_cnt); else n_pass++;
        n_checks++; if (done_cycle != LAT_DONE) $display("FAIL ignore_done_cycle: got %0d expected %0d", done_cycle, LAT_DONE); else n_pass++;
        n_checks++; if (addr_q.size() != N*N) $display("FAIL ignore_mem_en_cycles: got %0d expected %0d", addr_q.size(), N*N); else n_pass++;
        run_capture(8'd32, -1, 0, 1'b0, 1'b0);
        n_checks++; if (done_cycle != LAT_DONE) $display("FAIL restart_done_cycle: got %0d expected %0d", done_cycle, LAT_DONE); else n_pass++;
        n_checks++; if (log_data.size() < 1 || log_data[0][DW-1:0] !== 16'd330)
            $display("FAIL restart_step0_row0: got %0d expected 330", (log_data.size() > 0) ? log_data[0][DW-1:0] : 16'hxxxx); else n_pass++;
    endtask

    task automatic test_rst_abort();
        logic [N-1:0] ev; logic [N*DW-1:0] ed; int t, dones;
        @(negedge clk);
        i_base_addr = 8'd3;
        i_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            #1;
            i_start = 1'b0;
            if (k == 5) rst = 1'b1;
            @(posedge clk);
        end
        #1;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", o_busy); else n_pass++;
        n_checks++; if (o_mem_en !== 1'b0) $display("FAIL abort_mem_en: got %b expected 0", o_mem_en); else n_pass++;
        n_checks++; if (o_out_valid !== '0) $display("FAIL abort_valid: got %b expected 0", o_out_valid); else n_pass++;
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 30; k++) begin
            if (o_done) dones++;
            @(posedge clk); #1;
        end
        n_checks++; if (dones != 0) $display("FAIL abort_no_done: got %0d pulses expected 0", dones); else n_pass++;
        run_capture(8'd64, -1, 0, 1'b0, 1'b0);
        n_checks++; if (done_cycle != LAT_DONE) $display("FAIL abort_rerun_done: got %0d expected %0d", done_cycle, LAT_DONE); else n_pass++;
        t = 0;
        for (int j = 0; j < log_data.size(); j++) begin
            exp_step(8'd64, t, ev, ed);
            n_checks++; if (log_data[j] !== ed || log_valid[j] !== ev)
                $display("FAIL abort_rerun_step c%0d: got %h/%b expected %h/%b", j, log_data[j], log_valid[j], ed, ev); else n_pass++;
            if (log_ready[j]) t++;
        end
    endtask

    task automatic test_random();
        logic [N-1:0] ev; logic [N*DW-1:0] ed; int t, stalls; logic [AW-1:0] base;
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
            base = AW'($urandom);
            run_capture(base, -1, 0, 1'b1, 1'b0);
            t = 0; stalls = 0;
            for (int j = 0; j < log_data.size(); j++) begin
                exp_step(base, t, ev, ed);
                n_checks++; if (log_valid[j] !== ev) $display("FAIL rand%0d_valid c%0d: got %b expected %b", it, j, log_valid[j], ev); else n_pass++;
                n_checks++; if (log_data[j] !== ed) $display("FAIL rand%0d_data c%0d: got %h expected %h", it, j, log_data[j], ed); else n_pass++;
                if (log_ready[j]) t++; else stalls++;
            end
            n_checks++; if (log_data.size() != 2*N - 1 + stalls) $display("FAIL rand%0d_stream_len: got %0d expected %0d", it, log_data.size(), 2*N - 1 + stalls); else n_pass++;
            n_checks++; if (done_cycle != LAT_DONE + stalls) $display("FAIL rand%0d_done_cycle: got %0d expected %0d", it, done_cycle, LAT_DONE + stalls); else n_pass++;
            n_checks++; if (addr_q.size() != N*N) $display("FAIL rand%0d_mem_en_cycles: got %0d expected %0d", it, addr_q.size(), N*N); else n_pass++;
            for (int c = 0; c < addr_q.size() && c < N*N; c++) begin
                n_checks++; if (addr_q[c] !== AW'(base + AW'(c))) $display("FAIL rand%0d_addr[%0d]: got %0d expected %0d", it, c, addr_q[c], AW'(base + AW'(c))); else n_pass++;
            end
            n_checks++; if (wr_bad != 0) $display("FAIL rand%0d_mem_write: got %0d bad cycles expected 0", it, wr_bad); else n_pass++;
        end
    endtask

    initial begin
        load_default();
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_start_ignored();
        test_rst_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
